// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the seven-segment timer display.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; entry k sits at index k.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1011000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Clock cycles per counted step; 0 flags an unusable configuration.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
  endfunction

  // Prescaler width, never narrower than one bit.
  function automatic int unsigned calc_pw(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sevenseg_enc.sv
// Combinational 4-bit value to active-low seven-segment pattern.
module sevenseg_enc
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sevenseg_timer_display.sv
// Cascaded BCD up/down timer with hex-mode override and registered
// seven-segment outputs. Define SEVENSEG_LEADING_ZERO_BLANK_EN to blank
// leading zero digits (digit 0 always shown).
module sevenseg_timer_display
  import sevenseg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      run,
  input  logic                      clear,
  input  logic                      down,
  input  logic                      mode,
  input  logic [4*NUM_DIGITS-1:0]   value,
  output logic [7*NUM_DIGITS-1:0]   hex,
  output logic                      tick,
  output logic                      wrap
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PW  = calc_pw(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("sevenseg_timer_display: CLK_HZ/TICK_HZ must be at least 1");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    digit_q [NUM_DIGITS];
  logic [3:0]    digit_d [NUM_DIGITS];
  logic          tick_int;
  logic          carry_c;
  logic [3:0]    nib_c   [NUM_DIGITS];
  logic [6:0]    seg_c   [NUM_DIGITS];
  logic [6:0]    disp_c  [NUM_DIGITS];

  // Prescaler advance and ripple carry/borrow through the BCD digits.
  always_comb begin
    tick_int = run && (pre_q == PRE_LAST);
    pre_d    = pre_q;
    if (run) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
    carry_c = tick_int;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_d[i] = digit_q[i];
      if (carry_c) begin
        if (down) begin
          digit_d[i] = (digit_q[i] == 4'd0) ? 4'd9 : 4'(digit_q[i] - 4'd1);
          carry_c    = (digit_q[i] == 4'd0);
        end else begin
          digit_d[i] = (digit_q[i] == 4'd9) ? 4'd0 : 4'(digit_q[i] + 4'd1);
          carry_c    = (digit_q[i] == 4'd9);
        end
      end
    end
  end

  // Counter state; clear drops any tick landing in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      pre_q <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'd0;
    end else begin
      pre_q <= pre_d;
      tick  <= tick_int;
      wrap  <= carry_c;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
    end
  end

  // Per-digit source select and encoder.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign nib_c[g] = mode ? value[4*g +: 4] : digit_q[g];
    sevenseg_enc u_enc (
      .nibble (nib_c[g]),
      .seg    (seg_c[g])
    );
  end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  logic zero_run_c;

  // Blank digits above digit 0 while they and everything above them are zero.
  always_comb begin
    zero_run_c = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c && (nib_c[i] == 4'd0);
      disp_c[i]  = (zero_run_c && (i != 0)) ? SEG_BLANK : seg_c[i];
    end
  end
`else
  // Every digit shown as encoded.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) disp_c[i] = seg_c[i];
  end
`endif

  // Display register, refreshed every cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hex <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) hex[7*i +: 7] <= disp_c[i];
    end
  end

endmodule

// File: tb/tb_sevenseg_timer_display.sv
// Randomized self-checking bench for sevenseg_timer_display (2 digits, DIV=10).
module tb_sevenseg_timer_display;

  localparam int unsigned ND  = 2;
  localparam int unsigned DIV = 10;

  logic        CLK = 1'b0;
  logic        RST, run, clear, down, mode;
  logic [7:0]  value;
  logic [13:0] hex;
  logic        tick, wrap;

  sevenseg_timer_display #(
    .CLK_HZ     (10),
    .TICK_HZ    (1),
    .NUM_DIGITS (ND)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .run   (run),
    .clear (clear),
    .down  (down),
    .mode  (mode),
    .value (value),
    .hex   (hex),
    .tick  (tick),
    .wrap  (wrap)
  );

  always #5 CLK = ~CLK;

  logic [6:0] ENC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference: timer as an integer 0..99 plus prescaler count.
  int          m_pre = 0;
  int          m_cnt = 0;
  logic [13:0] m_hex = 14'h3FFF;
  logic        m_tick = 1'b0;
  logic        m_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] model_disp(input int cnt, input logic md, input logic [7:0] val);
    logic [3:0] n0, n1;
    logic [6:0] s1;
    n0 = md ? val[3:0] : 4'(cnt % 10);
    n1 = md ? val[7:4] : 4'(cnt / 10);
    s1 = ENC[n1];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    if (n1 == 4'd0) s1 = 7'h7F;
`endif
    return {s1, ENC[n0]};
  endfunction

  // One clock: advance the reference on the edge, then compare.
  task automatic step();
    logic t;
    @(posedge CLK);
    m_hex = RST ? 14'h3FFF : model_disp(m_cnt, mode, value);
    if (RST || clear) begin
      m_pre = 0; m_cnt = 0; m_tick = 1'b0; m_wrap = 1'b0;
    end else begin
      t      = run && (m_pre == DIV - 1);
      m_wrap = 1'b0;
      if (run) m_pre = (m_pre + 1) % DIV;
      if (t) begin
        if (down) begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + 99) % 100;
        end else begin
          m_wrap = (m_cnt == 99);
          m_cnt  = (m_cnt + 1) % 100;
        end
      end
      m_tick = t;
    end
    #1;
    check("hex",  32'(hex),  32'(m_hex));
    check("tick", 32'(tick), 32'(m_tick));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    RST = 1'b1; run = 1'b1; clear = 1'b0; down = 1'b0; mode = 1'b0; value = 8'h00;
    steps(2);
    check("rst_blank", 32'(hex), 32'h3FFF);
    RST = 1'b0;
    step();
    check("first_valid_d0", 32'(hex[6:0]), 32'(7'b1000000));

    // Count up through 09->10 and 99->00.
    steps(1010);

    // Down from 00: wrap to 99, then count through 10->09.
    clear = 1'b1; step(); clear = 1'b0;
    down = 1'b1;
    steps(950);

    // Pause mid-period, then clear on the tick cycle.
    down = 1'b0;
    for (int i = 0; i < 20 && m_pre != 4; i++) step();
    run = 1'b0;
    steps(25);
    run = 1'b1;
    for (int i = 0; i < 20 && m_pre != DIV - 1; i++) step();
    clear = 1'b1; step(); clear = 1'b0;
    steps(12);

    // Hex mode while the timer runs in the background.
    mode = 1'b1; value = 8'hA7;
    step();
    step();
    check("hexmode_a7", 32'(hex), 32'({7'b0001000, 7'b1011000}));
    steps(30);
    mode = 1'b0;
    steps(5);

    // Leading-zero region: 00 through 05.
    clear = 1'b1; step(); clear = 1'b0;
    steps(60);

    // Randomized control traffic.
    for (int i = 0; i < 4000; i++) begin
      RST   = ($urandom % 500) == 0;
      clear = ($urandom % 150) == 0;
      run   = ($urandom % 8) != 0;
      if (($urandom % 300) == 0) down = ~down;
      if (($urandom % 100) == 0) mode = ~mode;
      if (($urandom % 50) == 0)  value = 8'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
